sr_btn_ctrl: RTL and testbench
==============================

SR_BTN_CTRL -- requirements
Module: sr_btn_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 4, SHALL be the number of consecutive stable synchronized cycles required to accept a button level change (legal range 2..255).
REQ-002 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  reset SHALL be asynchronous and active-high.
REQ-004 Port set_btn  input  1  asynchronous, bouncing "set" button level.
REQ-005 Port clr_btn  input  1  asynchronous, bouncing "clear" button level.
REQ-006 Port s  output  1  registered one-cycle set pulse to the downstream SR flip-flop.
REQ-007 Port r  output  1  registered one-cycle reset pulse to the downstream SR flip-flop.
REQ-008 Port conflict  output  1  registered one-cycle pulse flagging simultaneously pending set and clear requests.
REQ-009 Port q_model  output  1  registered mirror of the downstream q: set by s, cleared by r.

Function
REQ-010 Each button SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-011 Each channel SHALL hold a debounced level and an 8-bit stability counter; the counter SHALL increment each cycle the synchronized input differs from the debounced level and SHALL clear whenever they match.
REQ-012 The debounced level SHALL toggle, and the counter SHALL clear, on the edge at which the counter would reach DB_CYCLES; shorter glitches SHALL leave the level unchanged.
REQ-013 A 0->1 transition of a debounced level SHALL set that channel's pending flag on the next edge; 1->0 transitions SHALL produce no request.
REQ-014 The arbiter FSM SHALL have states IDLE, PULSE_S, PULSE_R and GAP.
REQ-015 IDLE with only set pending -> PULSE_S, clearing set pending; IDLE with only clr pending -> PULSE_R, clearing clr pending.
REQ-016 IDLE with both pending -> stays IDLE, clears both pending flags, and asserts conflict for exactly one cycle; no s or r pulse SHALL be issued.
REQ-017 PULSE_S and PULSE_R SHALL each last one cycle, then go to GAP; GAP SHALL last one cycle, then go to IDLE.
REQ-018 s SHALL be 1 exactly while in PULSE_S; r SHALL be 1 exactly while in PULSE_R; s and r SHALL never both be 1.
REQ-019 New rising edges arriving during PULSE_S, PULSE_R or GAP SHALL set pending flags and be serviced from IDLE under REQ-015/016.
REQ-020 A rising edge on a channel whose pending flag is already set SHALL be merged into that flag; no second request SHALL be queued.
REQ-021 q_model SHALL become 1 on the edge that ends a PULSE_S cycle and 0 on the edge that ends a PULSE_R cycle; otherwise it SHALL hold.
REQ-022 Latency: if a clean press is first sampled at edge k, s SHALL be high during the cycle following edge k+DB_CYCLES+3 (IDLE, nothing else pending).
REQ-023 Minimum spacing between consecutive s/r pulses SHALL be 3 cycles (pulse, GAP, IDLE).

Reset
REQ-024 Asserting rst SHALL immediately force s=0, r=0, conflict=0, q_model=0, state IDLE, all synchronizer flops, debounced levels, counters and pending flags to 0.
REQ-025 rst asserted mid-pulse SHALL truncate the pulse asynchronously; no pending request SHALL survive reset.
REQ-026 A button held high through reset release SHALL be treated as a new press and produce one pulse after normal debounce latency.

Verification
REQ-027 DB_CYCLES=4, clean set_btn press sampled at edge 10 -> s=1 for exactly one cycle after edge 17; r=0; q_model=1 after edge 18.
REQ-028 set_btn glitch high for 3 cycles then low -> no s, r or conflict pulse; q_model unchanged.
REQ-029 set_btn and clr_btn pressed cleanly on the same edge -> conflict=1 for one cycle; s=r=0 throughout; q_model unchanged.
REQ-030 clr_btn press debounced during the PULSE_S cycle of a set press -> r pulse exactly 3 cycles after the s pulse; q_model 1 then 0.
REQ-031 rst raised during PULSE_S -> s falls without waiting for a clock edge; after release all outputs are 0 and no pulse follows unless a button is high.
REQ-032 Random bouncing stimulus, 10k cycles -> assertion that s&r is never 1 and q_model always equals a reference SR flip-flop model driven by s and r.

Source files
------------

// File: rtl/sr_btn_ctrl.sv
// sr_btn_ctrl: debounced set/clear buttons arbitrated into s/r pulses for an SR flip-flop
module sr_btn_ctrl #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic clr_btn,
    output logic s,
    output logic r,
    output logic conflict,
    output logic q_model
);
    typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_t;
    state_t state, state_n;
    logic [1:0] sync1, sync2, lvl, lvl_d, pend, rise, take;
    logic [7:0] cnt [2];
    logic conf_n;
    assign rise = lvl & ~lvl_d;
    // synchronize, debounce and latch rising-edge requests per channel (bit 0 set, bit 1 clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl <= '0;
            lvl_d <= '0;
            pend <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync1 <= {clr_btn, set_btn};
            sync2 <= sync1;
            lvl_d <= lvl;
            pend <= (pend & ~take) | rise;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != lvl[i]) begin
                    if (cnt[i] == 8'(DB_CYCLES - 1)) begin
                        lvl[i] <= ~lvl[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 8'd1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end
    // arbiter: one pulse per request, a gap cycle after each, simultaneous requests cancel
    always_comb begin
        state_n = state;
        take = 2'b00;
        conf_n = 1'b0;
        case (state)
            IDLE: begin
                if (pend == 2'b11) begin
                    take = 2'b11;
                    conf_n = 1'b1;
                end else if (pend[0]) begin
                    take = 2'b01;
                    state_n = PULSE_S;
                end else if (pend[1]) begin
                    take = 2'b10;
                    state_n = PULSE_R;
                end
            end
            PULSE_S, PULSE_R: state_n = GAP;
            default: state_n = IDLE;
        endcase
    end
    // state register and registered pulse outputs; q_model tracks the downstream flip-flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            s <= 1'b0;
            r <= 1'b0;
            conflict <= 1'b0;
            q_model <= 1'b0;
        end else begin
            state <= state_n;
            s <= state_n == PULSE_S;
            r <= state_n == PULSE_R;
            conflict <= conf_n;
            q_model <= s ? 1'b1 : r ? 1'b0 : q_model;
        end
    end
endmodule

// File: tb/tb_sr_btn_ctrl.sv
// tb_sr_btn_ctrl: directed and randomized checks of sr_btn_ctrl against a reference model
module tb_sr_btn_ctrl;
    localparam int DB = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic set_btn = 1'b0;
    logic clr_btn = 1'b0;
    logic s, r, conflict, q_model;
    int total = 0;
    int bad = 0;

    sr_btn_ctrl #(.DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .set_btn(set_btn), .clr_btn(clr_btn),
        .s(s), .r(r), .conflict(conflict), .q_model(q_model)
    );

    always #5 clk = ~clk;

    // reference model: two-sample delay, run-length debounce, request flags and a busy countdown
    bit [1:0] y1 = '0, y2 = '0, lv = '0, lvp = '0, pd = '0;
    int run [2] = '{0, 0};
    int busy = 0;
    bit ms = 0, mr = 0, mc = 0, mq = 0;

    always @(posedge clk or posedge rst) begin
        bit [1:0] rise, take;
        if (rst) begin
            y1 = '0; y2 = '0; lv = '0; lvp = '0; pd = '0;
            run[0] = 0; run[1] = 0;
            busy = 0; ms = 0; mr = 0; mc = 0; mq = 0;
        end else begin
            rise = lv & ~lvp;
            lvp = lv;
            for (int c = 0; c < 2; c++) begin
                run[c] = (y2[c] != lv[c]) ? run[c] + 1 : 0;
                if (run[c] == DB) begin
                    lv[c] = ~lv[c];
                    run[c] = 0;
                end
            end
            y2 = y1;
            y1 = {clr_btn, set_btn};
            if (ms) mq = 1;
            else if (mr) mq = 0;
            ms = 0; mr = 0; mc = 0; take = '0;
            if (busy > 0) busy--;
            else if (pd == 2'b11) begin mc = 1; take = 2'b11; end
            else if (pd[0]) begin ms = 1; take = 2'b01; busy = 2; end
            else if (pd[1]) begin mr = 1; take = 2'b10; busy = 2; end
            pd = (pd & ~take) | rise;
        end
    end

    task automatic apply_reset();
        set_btn = 0;
        clr_btn = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        #1 rst = 1;
        #1;
        total++; if ({s, r, conflict, q_model} !== 4'b0000) begin bad++; $display("FAIL reset_outputs got=%b want=0000", {s, r, conflict, q_model}); end
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        total++; if ({s, r, conflict, q_model} !== 4'b0000) begin bad++; $display("FAIL reset_idle got=%b want=0000", {s, r, conflict, q_model}); end
    endtask

    task automatic test_latency();
        apply_reset();
        @(negedge clk);
        set_btn = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++; if (s !== (i == 7)) begin bad++; $display("FAIL latency_s i=%0d got=%b want=%b", i, s, i == 7); end
            total++; if (r !== 1'b0) begin bad++; $display("FAIL latency_r i=%0d got=%b want=0", i, r); end
            total++; if (q_model !== (i >= 8)) begin bad++; $display("FAIL latency_q i=%0d got=%b want=%b", i, q_model, i >= 8); end
            total++; if (s !== ms) begin bad++; $display("FAIL latency_model i=%0d got=%b want=%b", i, s, ms); end
        end
        set_btn = 0;
    endtask

    task automatic test_glitch();
        apply_reset();
        @(negedge clk);
        set_btn = 1;
        repeat (3) @(negedge clk);
        set_btn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++; if ({s, r, conflict, q_model} !== 4'b0000) begin bad++; $display("FAIL glitch i=%0d got=%b want=0000", i, {s, r, conflict, q_model}); end
        end
    endtask

    task automatic test_conflict();
        apply_reset();
        @(negedge clk);
        set_btn = 1;
        clr_btn = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++; if (conflict !== (i == 7)) begin bad++; $display("FAIL conflict_flag i=%0d got=%b want=%b", i, conflict, i == 7); end
            total++; if ({s, r, q_model} !== 3'b000) begin bad++; $display("FAIL conflict_srq i=%0d got=%b want=000", i, {s, r, q_model}); end
        end
        set_btn = 0;
        clr_btn = 0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        @(negedge clk);
        set_btn = 1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 1) clr_btn = 1;
            total++; if (s !== (i == 7)) begin bad++; $display("FAIL b2b_s i=%0d got=%b want=%b", i, s, i == 7); end
            total++; if (r !== (i == 10)) begin bad++; $display("FAIL b2b_r i=%0d got=%b want=%b", i, r, i == 10); end
            total++; if (q_model !== (i >= 8 && i <= 10)) begin bad++; $display("FAIL b2b_q i=%0d got=%b want=%b", i, q_model, i >= 8 && i <= 10); end
        end
        set_btn = 0;
        clr_btn = 0;
    endtask

    task automatic test_reset_mid_pulse();
        int pulses;
        apply_reset();
        @(negedge clk);
        set_btn = 1;
        repeat (8) @(negedge clk);
        total++; if (s !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b want=1", s); end
        #1 rst = 1;
        #1;
        total++; if ({s, r, conflict, q_model} !== 4'b0000) begin bad++; $display("FAIL midrst_async got=%b want=0000", {s, r, conflict, q_model}); end
        set_btn = 0;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            total++; if ({s, r, conflict, q_model} !== 4'b0000) begin bad++; $display("FAIL midrst_after i=%0d got=%b want=0000", i, {s, r, conflict, q_model}); end
        end
        set_btn = 1;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            pulses += int'(s);
            total++; if (s !== (i == 7)) begin bad++; $display("FAIL held_s i=%0d got=%b want=%b", i, s, i == 7); end
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL held_count got=%0d want=1", pulses); end
        set_btn = 0;
    endtask

    task automatic test_random();
        bit ts = 0, tc = 0;
        apply_reset();
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            total++; if ((s & r) !== 1'b0) begin bad++; $display("FAIL rand_sr n=%0d s=%b r=%b want not both", n, s, r); end
            total++; if ({s, r, conflict, q_model} !== {ms, mr, mc, mq}) begin bad++; $display("FAIL rand_model n=%0d got=%b want=%b", n, {s, r, conflict, q_model}, {ms, mr, mc, mq}); end
            if ($urandom_range(0, 99) < 4) ts = ~ts;
            if ($urandom_range(0, 99) < 4) tc = ~tc;
            set_btn = ($urandom_range(0, 99) < 12) ? ~ts : ts;
            clr_btn = ($urandom_range(0, 99) < 12) ? ~tc : tc;
            if (n % 2500 == 1250) begin
                #2 rst = 1;
                #2 rst = 0;
            end
        end
        set_btn = 0;
        clr_btn = 0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_conflict();
        test_back_to_back();
        test_reset_mid_pulse();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
